div_restoring_seq: RTL and testbench
====================================

// Module: div_restoring_seq
// PURPOSE
//   Multi-cycle restoring integer divider for the RV32M DIV/DIVU/REM/REMU path.
//   One substract #(WIDTH+1) instance is time-shared over WIDTH iterations.
//   The block sequences that instance and drives its operands and borrow-in.
//   Sits beside the ALU; the core stalls on busy_o and captures results on done_o.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be >= 2
// PORTS
//   clk_i        in   1      clock, all state updates on rising edge
//   rst_i        in   1      synchronous reset, active-high
//   start_i      in   1      request; sampled only in IDLE
//   signed_i     in   1      1 = signed operation (used only with DIV_SIGNED_EN)
//   dividend_i   in   WIDTH  dividend, sampled with start_i
//   divisor_i    in   WIDTH  divisor, sampled with start_i
//   busy_o       out  1      1 while state != IDLE
//   done_o       out  1      one-cycle pulse, results valid
//   quotient_o   out  WIDTH  registered quotient, held until next accepted start
//   remainder_o  out  WIDTH  registered remainder, held until next accepted start
// BEHAVIOUR
//   - Reset (rst_i=1 on an edge): state=IDLE; busy_o=0, done_o=0, quotient_o=0,
//     remainder_o=0; internal rem/quo/count regs cleared. Applies in any state.
//     A division in flight is aborted with no done_o.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: start_i=1 latches operands. Divisor==0 goes to DONE.
//       Otherwise goes to RUN with count=0, rem=0, quo=dividend.
//     RUN: one iteration per cycle. Leaves for DONE after iteration WIDTH-1.
//     DONE: done_o=1 for exactly this cycle; results loaded; always -> IDLE.
//   - start_i is ignored in RUN and DONE; no queuing.
//   - Iteration (WIDTH+1-bit arithmetic):
//       shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
//       substract A_i=shifted, B_i={1'b0,divisor}, Bin_i=0.
//       Bout_o==0 -> rem=S_o, quo={quo[WIDTH-2:0],1}.
//       Otherwise -> rem=shifted, quo={quo[WIDTH-2:0],0}.
//   - Latency: start accepted at edge t; RUN spans t+1..t+WIDTH.
//     done_o=1 in cycle t+WIDTH+1 (33 cycles for WIDTH=32).
//     Divide-by-zero: done_o=1 in cycle t+1.
//   - Divide-by-zero result (RISC-V): quotient_o = all ones, remainder_o = dividend.
//     No sign fixup is applied.
//   - A new start_i may be accepted in the IDLE cycle right after DONE.
//   - quotient_o/remainder_o change only on entry to DONE, or on reset.
// CONFIGURATION
//   Macro DIV_SIGNED_EN:
//   - Defined, signed_i=1: operands are converted to magnitudes at start.
//     Quotient is negated if the operand signs differ.
//     Remainder takes the dividend's sign.
//     Overflow (-2^(WIDTH-1) / -1) yields quotient = dividend, remainder = 0,
//     at normal latency.
//   - Defined, signed_i=0: unsigned operation.
//   - Not defined: signed_i is ignored and all operations are unsigned.
//     No abs/negate logic is synthesised.
// TESTING
//   1. Unsigned 100/7, start at t -> done_o only at t+33; q=0x0000000E, r=0x00000002;
//      busy_o=1 for t+1..t+33.
//   2. 0xFFFFFFFF / 0x00000001 -> q=0xFFFFFFFF, r=0; 0x00000005 / 0x00000009 -> q=0, r=5.
//   3. 0x00001234 / 0 -> done_o at t+1; q=0xFFFFFFFF, r=0x00001234.
//   4. [DIV_SIGNED_EN] signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//      0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
//   5. start_i pulsed again at t+5 with other operands -> ignored; first result unchanged.
//   6. rst_i=1 at t+10 mid-RUN -> next cycle busy_o=0, outputs 0, no done_o.
//      A following start completes normally.

Source files
------------

// File: rtl/div_restoring_seq.sv
// Multi-cycle restoring divider: one shared WIDTH+1-bit subtractor, one quotient bit per cycle.
// Optional signed support (abs at start, sign fixup at the end) is enabled by defining DIV_SIGNED_EN.

module substract #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Bin_i,
    output logic [WIDTH-1:0] S_o,
    output logic             Bout_o
);

    logic [WIDTH:0] diff;

    assign diff   = {1'b0, A_i} - {1'b0, B_i} - {{WIDTH{1'b0}}, Bin_i};
    assign S_o    = diff[WIDTH-1:0];
    assign Bout_o = diff[WIDTH];

endmodule

module div_restoring_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_s;
    logic             sub_bout;
    logic [WIDTH-1:0] iter_rem;
    logic [WIDTH-1:0] iter_quo;
    logic             div_zero;
    logic             last_iter;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic dvd_neg;
    logic dvs_neg;
    logic unused_bits;

    assign unused_bits = ^{sub_s[WIDTH], shifted[WIDTH]};
`else
    logic unused_bits;

    assign unused_bits = ^{sub_s[WIDTH], shifted[WIDTH], signed_i};
`endif

    substract #(WIDTH + 1) u_sub (
        .A_i    (shifted),
        .B_i    ({1'b0, dvs_q}),
        .Bin_i  (1'b0),
        .S_o    (sub_s),
        .Bout_o (sub_bout)
    );

    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign iter_rem  = sub_bout ? shifted[WIDTH-1:0] : sub_s[WIDTH-1:0];
    assign iter_quo  = {quo_q[WIDTH-2:0], ~sub_bout};
    assign div_zero  = (divisor_i == '0);
    assign last_iter = (count_q == LAST_ITER);

    // Operand magnitudes and final sign fixup exist only in the signed build.
`ifdef DIV_SIGNED_EN
    assign dvd_neg   = signed_i & dividend_i[WIDTH-1];
    assign dvs_neg   = signed_i & divisor_i[WIDTH-1];
    assign dvd_mag   = dvd_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
    assign dvs_mag   = dvs_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;
    assign quo_final = neg_quo_q ? (~iter_quo + WIDTH'(1)) : iter_quo;
    assign rem_final = neg_rem_q ? (~iter_rem + WIDTH'(1)) : iter_rem;
`else
    assign dvd_mag   = dividend_i;
    assign dvs_mag   = divisor_i;
    assign quo_final = iter_quo;
    assign rem_final = iter_rem;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        quotient_o  = quotient_q;
        remainder_o = remainder_q;
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (div_zero) begin
                        // Divide-by-zero returns the raw dividend, never sign-fixed.
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                    end else begin
                        rem_d   = '0;
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        count_d = '0;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d   = iter_rem;
                quo_d   = iter_quo;
                count_d = count_q + CW'(1);
                if (last_iter) begin
                    quotient_d  = quo_final;
                    remainder_d = rem_final;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed bench for div_restoring_seq (WIDTH=32): latency, results, divide-by-zero,
// ignored starts, mid-run reset and back-to-back operation.

module tb_div_restoring_seq;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;

    int total = 0;
    int bad   = 0;

    div_restoring_seq #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a request for one edge; returns in the first cycle after acceptance.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    // n counts cycles after acceptance; the current cycle is n0.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        signed_i = 1'b0;
        dividend_i = '0;
        divisor_i = '0;
        step();
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        total++; if (quotient_o !== '0) begin bad++; $display("FAIL reset_q got=%h want=0", quotient_o); end
        total++; if (remainder_o !== '0) begin bad++; $display("FAIL reset_r got=%h want=0", remainder_o); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        start_op(32'd100, 32'd7, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy cycle=%0d got=%b want=1", k, busy_o); end
            total++;
            if (done_o !== (k == LAT)) begin
                bad++; $display("FAIL basic_done cycle=%0d got=%b want=%b", k, done_o, (k == LAT));
            end
            if (k < LAT) step();
        end
        total++; if (quotient_o !== 32'h0000000E) begin bad++; $display("FAIL basic_q got=%h want=0000000e", quotient_o); end
        total++; if (remainder_o !== 32'h00000002) begin bad++; $display("FAIL basic_r got=%h want=00000002", remainder_o); end
        step();
        total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL basic_idle busy=%b done=%b want 0 0", busy_o, done_o); end
        total++; if (quotient_o !== 32'h0000000E) begin bad++; $display("FAIL basic_hold got=%h want=0000000e", quotient_o); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5] = '{32'hFFFFFFFF, 32'h00000005, 32'h000003E8, 32'hFFFFFFF9, 32'h80000000};
        logic [W-1:0] vb [5] = '{32'h00000001, 32'h00000009, 32'h0000000A, 32'h00000002, 32'hFFFFFFFF};
        logic [W-1:0] vq [5] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000064, 32'h7FFFFFFC, 32'h00000000};
        logic [W-1:0] vr [5] = '{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000001, 32'h80000000};
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_done(1, lat);
            total++; if (lat !== LAT) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT); end
            total++; if (quotient_o !== vq[i]) begin bad++; $display("FAIL vec%0d_q got=%h want=%h", i, quotient_o, vq[i]); end
            total++; if (remainder_o !== vr[i]) begin bad++; $display("FAIL vec%0d_r got=%h want=%h", i, remainder_o, vr[i]); end
            step();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(32'h00001234, 32'h0, 1'b0);
        wait_done(1, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
        total++; if (quotient_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_q got=%h want=ffffffff", quotient_o); end
        total++; if (remainder_o !== 32'h00001234) begin bad++; $display("FAIL dz_r got=%h want=00001234", remainder_o); end
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL dz_idle got=%b want=0", busy_o); end
    endtask

    task automatic test_signed();
        int lat;
`ifdef DIV_SIGNED_EN
        start_op(32'hFFFFFFF9, 32'h00000002, 1'b1);
        wait_done(1, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL sgn_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'hFFFFFFFD) begin bad++; $display("FAIL sgn_q got=%h want=fffffffd", quotient_o); end
        total++; if (remainder_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL sgn_r got=%h want=ffffffff", remainder_o); end
        step();
        start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(1, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'h80000000) begin bad++; $display("FAIL ovf_q got=%h want=80000000", quotient_o); end
        total++; if (remainder_o !== 32'h00000000) begin bad++; $display("FAIL ovf_r got=%h want=00000000", remainder_o); end
        step();
        start_op(32'hFFFFFFF9, 32'h00000000, 1'b1);
        wait_done(1, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL sgn_dz_latency got=%0d want=1", lat); end
        total++; if (quotient_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL sgn_dz_q got=%h want=ffffffff", quotient_o); end
        total++; if (remainder_o !== 32'hFFFFFFF9) begin bad++; $display("FAIL sgn_dz_r got=%h want=fffffff9", remainder_o); end
        step();
`else
        // signed_i has no effect in the unsigned-only build.
        start_op(32'hFFFFFFF9, 32'h00000002, 1'b1);
        wait_done(1, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL sgn_ign_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'h7FFFFFFC) begin bad++; $display("FAIL sgn_ign_q got=%h want=7ffffffc", quotient_o); end
        total++; if (remainder_o !== 32'h00000001) begin bad++; $display("FAIL sgn_ign_r got=%h want=00000001", remainder_o); end
        step();
`endif
    endtask

    task automatic test_ignore_start();
        int lat;
        start_op(32'd100, 32'd7, 1'b0);
        step();
        step();
        step();
        step();
        start_op(32'd50, 32'd3, 1'b0);
        wait_done(6, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'h0000000E) begin bad++; $display("FAIL ign_q got=%h want=0000000e", quotient_o); end
        total++; if (remainder_o !== 32'h00000002) begin bad++; $display("FAIL ign_r got=%h want=00000002", remainder_o); end
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_no_requeue got=%b want=0", busy_o); end
    endtask

    task automatic test_abort();
        int lat;
        bit saw_done;
        start_op(32'd1000, 32'd10, 1'b0);
        for (int k = 0; k < 9; k++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done_o); end
        total++; if (quotient_o !== '0) begin bad++; $display("FAIL abort_q got=%h want=0", quotient_o); end
        total++; if (remainder_o !== '0) begin bad++; $display("FAIL abort_r got=%h want=0", remainder_o); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done_o === 1'b1 || busy_o === 1'b1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_quiet got=%b want=0", saw_done); end
        start_op(32'd1000, 32'd10, 1'b0);
        wait_done(1, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL abort_rerun_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'd100) begin bad++; $display("FAIL abort_rerun_q got=%h want=00000064", quotient_o); end
        total++; if (remainder_o !== 32'd0) begin bad++; $display("FAIL abort_rerun_r got=%h want=0", remainder_o); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'd100, 32'd7, 1'b0);
        wait_done(1, lat);
        // Request held through DONE: ignored there, accepted in the following IDLE cycle.
        dividend_i = 32'd5;
        divisor_i  = 32'd9;
        start_i    = 1'b1;
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_done_ignores got=%b want=0", busy_o); end
        step();
        start_i = 1'b0;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy_o); end
        total++; if (quotient_o !== 32'h0000000E) begin bad++; $display("FAIL b2b_hold_q got=%h want=0000000e", quotient_o); end
        wait_done(1, lat);
        total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient_o !== 32'h0) begin bad++; $display("FAIL b2b_q got=%h want=0", quotient_o); end
        total++; if (remainder_o !== 32'h5) begin bad++; $display("FAIL b2b_r got=%h want=00000005", remainder_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_signed();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
